// File: rtl/timer_pkg.sv
// Shared constants for the timer display path: active-low 7-segment codes
// and count limits, plus the BCD digit to segment lookup.
package timer_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int         NUM_DIGITS = 4;
  localparam logic [5:0] MAX_COUNT  = 6'd59;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd60.sv
// Converts a 0..59 binary count to BCD tens/ones with a comparison chain;
// values above 59 raise invalid.
module bin2bcd60
  import timer_pkg::*;
(
  input  logic [5:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       invalid
);

  // Tens chosen by threshold compare, ones by the matching subtraction.
  always_comb begin
    invalid = (value > MAX_COUNT);
    tens    = 4'd0;
    ones    = 4'd0;
    if (invalid) begin
      tens = 4'd0;
      ones = 4'd0;
    end else if (value >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(value - 6'd50);
    end else if (value >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(value - 6'd40);
    end else if (value >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(value - 6'd30);
    end else if (value >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(value - 6'd20);
    end else if (value >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(value - 6'd10);
    end else begin
      tens = 4'd0;
      ones = value[3:0];
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexes MM:SS onto a 4-digit common-anode display with a 1 Hz colon
// and whole-display flashing while paused.
module seg_scan_display
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic       pause,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              DIV       = CLK_HZ / (4 * SCAN_HZ);
  localparam int              CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int              HALF      = SCAN_HZ / 2;
  localparam int              BW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = CW'(DIV - 1);
  localparam logic [BW-1:0]   BLINK_MAX = BW'(HALF - 1);
  localparam logic [1:0]      LAST_IDX  = 2'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [5:0]    sec_sh_r;
  logic [5:0]    min_sh_r;
  logic [BW-1:0] blink_r;
  logic          col_r;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  logic          tick_s;
  logic          wrap_s;
  logic [3:0]    sec_tens_s, sec_ones_s, min_tens_s, min_ones_s;
  logic          sec_inv_s, min_inv_s;
  logic [3:0]    digit_s;
  logic          inv_s;
  logic [6:0]    seg_s;
  logic [3:0]    an_s;

  assign tick_s = (cnt_r == CNT_MAX);
  assign wrap_s = tick_s && (idx_r == LAST_IDX);

  bin2bcd60 u_sec_bcd (
    .value   (sec_sh_r),
    .tens    (sec_tens_s),
    .ones    (sec_ones_s),
    .invalid (sec_inv_s)
  );

  bin2bcd60 u_min_bcd (
    .value   (min_sh_r),
    .tens    (min_tens_s),
    .ones    (min_ones_s),
    .invalid (min_inv_s)
  );

  // Prescaler, digit index, frame-boundary shadow capture and colon phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= '0;
      idx_r    <= 2'd0;
      sec_sh_r <= 6'd0;
      min_sh_r <= 6'd0;
      blink_r  <= '0;
      col_r    <= 1'b0;
    end else begin
      cnt_r <= tick_s ? '0 : cnt_r + 1'b1;
      if (tick_s) begin
        idx_r <= idx_r + 2'd1;
      end
      if (wrap_s) begin
        sec_sh_r <= sec;
        min_sh_r <= min;
        if (blink_r == BLINK_MAX) begin
          blink_r <= '0;
          col_r   <= ~col_r;
        end else begin
          blink_r <= blink_r + 1'b1;
        end
      end
    end
  end

  // Select the digit for the current scan position.
  always_comb begin
    digit_s = 4'd0;
    inv_s   = 1'b0;
    case (idx_r)
      2'd0: begin digit_s = sec_ones_s; inv_s = sec_inv_s; end
      2'd1: begin digit_s = sec_tens_s; inv_s = sec_inv_s; end
      2'd2: begin digit_s = min_ones_s; inv_s = min_inv_s; end
      2'd3: begin digit_s = min_tens_s; inv_s = min_inv_s; end
      default: begin digit_s = 4'd0; inv_s = 1'b1; end
    endcase
    seg_s = inv_s ? SEG_DASH : bcd_to_seg(digit_s);
    an_s  = ~(4'b0001 << idx_r);
  end

  // Registered drive; pause blanks only the anodes, scanning continues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_r  <= 4'b1110;
      seg_r <= SEG_0;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= (pause && !col_r) ? 4'b1111 : an_s;
      seg_r <= seg_s;
      dp_r  <= !((idx_r == 2'd2) && col_r);
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display at CLK_HZ=64, SCAN_HZ=4 (4 clks per digit,
// 16 per frame, colon phase 32 clks); expected outputs go through a scoreboard queue.
module tb_seg_scan_display;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] sec;
  logic [5:0] min;
  logic       pause;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int   checks = 0;
  int   failures = 0;
  int   k = 0;
  int   sh_sec = 0;
  int   sh_min = 0;
  exp_t sb_q[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  seg_scan_display #(.CLK_HZ(64), .SCAN_HZ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .sec   (sec),
    .min   (min),
    .pause (pause),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output expected after an edge preceded by n edges since reset release.
  function automatic exp_t model(input int n, input int ss, input int sm, input logic p);
    exp_t       e;
    int         idx;
    int         col;
    int         v;
    int         d;
    logic [3:0] one;
    idx = (n / 4) % 4;
    col = (n / 32) % 2;
    v   = (idx < 2) ? ss : sm;
    d   = (idx % 2 == 0) ? (v % 10) : (v / 10);
    one = 4'b0001;
    one = one << idx;
    e.seg = (v > 59) ? 7'b0111111 : seg_tab[d];
    e.an  = (p && col == 0) ? 4'b1111 : ~one;
    e.dp  = (idx == 2 && col == 1) ? 1'b0 : 1'b1;
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb_q.pop_front();
      checks++;
      assert (an === e.an) else begin
        failures++;
        $error("FAIL %s an k=%0d observed=%b expected=%b", tag, k, an, e.an);
      end
      checks++;
      assert (seg === e.seg) else begin
        failures++;
        $error("FAIL %s seg k=%0d observed=%b expected=%b", tag, k, seg, e.seg);
      end
      checks++;
      assert (dp === e.dp) else begin
        failures++;
        $error("FAIL %s dp k=%0d observed=%b expected=%b", tag, k, dp, e.dp);
      end
    end
  endtask

  task automatic push_reset_state();
    exp_t e;
    e.an  = 4'b1110;
    e.seg = 7'b1000000;
    e.dp  = 1'b1;
    sb_q.push_back(e);
  endtask

  // One clock edge: predict, advance, compare.
  task automatic step(input string tag);
    sb_q.push_back(model(k, sh_sec, sh_min, pause));
    if (k % 16 == 15) begin
      sh_sec = sec;
      sh_min = min;
    end
    k++;
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic run_to(input int target, input string tag);
    while (k < target) step(tag);
  endtask

  initial begin
    reset = 1'b0;
    sec   = 6'd0;
    min   = 6'd0;
    pause = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    push_reset_state();
    compare("reset_hold");

    reset  = 1'b1;
    k      = 0;
    sh_sec = 0;
    sh_min = 0;
    run_to(20, "scan_order");

    min = 6'd12;
    sec = 6'd34;
    run_to(48, "frame_latch_1234");

    sec = 6'd59;
    run_to(69, "sec59");
    sec = 6'd0;
    run_to(96, "sec_change_mid_frame");

    sec = 6'd60;
    min = 6'd63;
    run_to(128, "invalid_dash");

    pause = 1'b1;
    sec   = 6'd5;
    min   = 6'd7;
    run_to(191, "pause_flash");
    pause = 1'b0;
    run_to(220, "pause_release_at_wrap");

    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    push_reset_state();
    compare("async_reset_mid_frame");
    @(posedge clk);
    #1;
    push_reset_state();
    compare("reset_mid_hold");

    reset  = 1'b1;
    k      = 0;
    sh_sec = 0;
    sh_min = 0;
    run_to(40, "after_reset_0705");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
